spi_register_bridge: RTL and testbench

- Slow-domain byte-protocol engine that sits directly downstream of the dual-clock SPI device.
- Consumes received bytes (rx_data/rx_strobe), decodes a command byte and performs register writes or reads with auto-increment.
- Returns read data to the SPI device as response bytes (tx_data/tx_strobe).
- Framing comes from SPI chip-select, synchronised internally; an inactivity timeout aborts stalled frames.

---
 rtl/spi_register_bridge_if.sv | 23 ++
 rtl/spi_register_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_spi_register_bridge.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_register_bridge_if.sv
// Byte-stream and register-bus bundle between the SPI byte engine and its register file.
// master = bridge side, slave = SPI device / register file side.
interface spi_register_bridge_if;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_strobe;
    logic       reg_rd_strobe;
    logic [7:0] reg_rd_data;

    modport master (
        input  rx_data, rx_strobe, reg_rd_data,
        output tx_data, tx_strobe, reg_addr, reg_wr_data, reg_wr_strobe, reg_rd_strobe
    );

    modport slave (
        output rx_data, rx_strobe, reg_rd_data,
        input  tx_data, tx_strobe, reg_addr, reg_wr_data, reg_wr_strobe, reg_rd_strobe
    );
endinterface

// File: rtl/spi_register_bridge.sv
// Command decoder turning SPI bytes into register writes / auto-incrementing reads.
// Latency: write strobe 1 cycle after byte; read strobe +1, tx_strobe +3 after command byte.
// No backpressure: bytes arriving mid-read are dropped and flagged on frame_error.
module spi_register_bridge #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int AUTO_INCREMENT = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         spi_cs_n,
    spi_register_bridge_if.master        bus,
    output logic                         frame_error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_LOAD  = 3'd4,
        RD_IDLE  = 3'd5
    } state_t;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit              INC_EN   = (AUTO_INCREMENT != 0);

    logic             cs_meta;
    logic             cs_s;
    state_t           state;
    state_t           state_nxt;
    logic [6:0]       addr;
    logic [6:0]       addr_nxt;
    logic [6:0]       addr_inc;
    logic [CNT_W-1:0] to_cnt;
    logic             counting;
    logic             timeout_hit;
    logic             lock;

    logic [7:0]       tx_data_q,  tx_data_d;
    logic             tx_stb_q,   tx_stb_d;
    logic [6:0]       raddr_q,    raddr_d;
    logic [7:0]       wr_data_q,  wr_data_d;
    logic             wr_stb_q,   wr_stb_d;
    logic             rd_stb_q,   rd_stb_d;
    logic             err_q,      err_d;

    // chip select is asynchronous to clk; idle level is deasserted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
        end else begin
            cs_meta <= spi_cs_n;
            cs_s    <= cs_meta;
        end
    end

    assign addr_inc    = INC_EN ? addr + 7'd1 : addr;
    assign counting    = TO_EN && !cs_s && (state != IDLE);
    assign timeout_hit = counting && !bus.rx_strobe && (to_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (!counting || bus.rx_strobe) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // after a timeout the rest of the frame is ignored until cs deasserts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock <= 1'b0;
        end else if (cs_s) begin
            lock <= 1'b0;
        end else if (timeout_hit) begin
            lock <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_s || timeout_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_strobe && !lock) begin
                        state_nxt = bus.rx_data[7] ? RD_ISSUE : WRITE;
                    end
                end
                WRITE:    state_nxt = WRITE;
                RD_ISSUE: state_nxt = RD_WAIT;
                RD_WAIT:  state_nxt = RD_LOAD;
                RD_LOAD:  state_nxt = RD_IDLE;
                RD_IDLE: begin
                    if (bus.rx_strobe) begin
                        state_nxt = RD_ISSUE;
                    end
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // next values of the registered outputs; a closing frame suppresses every new action
    always_comb begin
        addr_nxt  = addr;
        tx_data_d = tx_data_q;
        tx_stb_d  = 1'b0;
        raddr_d   = raddr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        err_d     = timeout_hit;
        if (!cs_s) begin
            case (state)
                IDLE: begin
                    if (bus.rx_strobe && !lock) begin
                        addr_nxt = bus.rx_data[6:0];
                        if (bus.rx_data[7]) begin
                            rd_stb_d = 1'b1;
                            raddr_d  = bus.rx_data[6:0];
                        end
                    end
                end
                WRITE: begin
                    if (bus.rx_strobe) begin
                        wr_stb_d  = 1'b1;
                        wr_data_d = bus.rx_data;
                        raddr_d   = addr;
                        addr_nxt  = addr_inc;
                    end
                end
                RD_ISSUE: begin
                    err_d = err_d | bus.rx_strobe;
                end
                RD_WAIT: begin
                    err_d = err_d | bus.rx_strobe;
                    if (state_nxt == RD_LOAD) begin
                        tx_stb_d  = 1'b1;
                        tx_data_d = bus.reg_rd_data;
                    end
                end
                RD_LOAD: begin
                    err_d    = err_d | bus.rx_strobe;
                    addr_nxt = addr_inc;
                end
                RD_IDLE: begin
                    if (bus.rx_strobe) begin
                        rd_stb_d = 1'b1;
                        raddr_d  = addr;
                    end
                end
                default: begin
                    addr_nxt = addr;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            tx_data_q <= '0;
            tx_stb_q  <= 1'b0;
            raddr_q   <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            addr      <= addr_nxt;
            tx_data_q <= tx_data_d;
            tx_stb_q  <= tx_stb_d;
            raddr_q   <= raddr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.tx_strobe     = tx_stb_q;
    assign bus.reg_addr      = raddr_q;
    assign bus.reg_wr_data   = wr_data_q;
    assign bus.reg_wr_strobe = wr_stb_q;
    assign bus.reg_rd_strobe = rd_stb_q;
    assign frame_error       = err_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Directed bench: main bridge (timeout 20, auto-increment) and a fixed-address,
// no-timeout bridge share the same SPI byte stream; a small register file answers reads.
module tb_spi_register_bridge;
    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       spi_cs_n  = 1'b1;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       frame_error;
    logic       frame_error2;

    int total = 0;
    int bad   = 0;
    int tx_cnt = 0, err_cnt = 0, wr_cnt = 0, err2_cnt = 0;
    int t0, e0, w0, e20, pulses, first_err;
    logic [7:0] mem [0:127];

    spi_register_bridge_if bus();
    spi_register_bridge_if bus2();

    assign bus.rx_data    = rx_data;
    assign bus.rx_strobe  = rx_strobe;
    assign bus2.rx_data   = rx_data;
    assign bus2.rx_strobe = rx_strobe;
    assign bus2.reg_rd_data = 8'h00;

    spi_register_bridge #(.TIMEOUT_CYCLES(20), .AUTO_INCREMENT(1)) dut (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .bus(bus), .frame_error(frame_error)
    );

    spi_register_bridge #(.TIMEOUT_CYCLES(0), .AUTO_INCREMENT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(spi_cs_n), .bus(bus2), .frame_error(frame_error2)
    );

    always #5 clk = ~clk;

    // register file: read data valid the cycle after reg_rd_strobe
    always @(posedge clk) begin
        if (bus.reg_wr_strobe) mem[bus.reg_addr] <= bus.reg_wr_data;
        if (bus.reg_rd_strobe) bus.reg_rd_data <= mem[bus.reg_addr];
        if (bus.tx_strobe)     tx_cnt   <= tx_cnt + 1;
        if (frame_error)       err_cnt  <= err_cnt + 1;
        if (bus.reg_wr_strobe) wr_cnt   <= wr_cnt + 1;
        if (frame_error2)      err2_cnt <= err2_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic cs_fall();
        spi_cs_n = 1'b0;
        cyc(3);
    endtask

    task automatic cs_rise();
        spi_cs_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        cyc(3);
        chk("rst tx_data",     bus.tx_data, 8'h00);
        chk("rst tx_strobe",   bus.tx_strobe, 1'b0);
        chk("rst reg_addr",    bus.reg_addr, 7'h00);
        chk("rst wr_data",     bus.reg_wr_data, 8'h00);
        chk("rst wr_strobe",   bus.reg_wr_strobe, 1'b0);
        chk("rst rd_strobe",   bus.reg_rd_strobe, 1'b0);
        chk("rst frame_error", frame_error, 1'b0);
        reset_n = 1'b1;
        cyc(2);

        // write burst
        t0 = tx_cnt;
        cs_fall();
        send(8'h05);
        chk("wb cmd no write", bus.reg_wr_strobe, 1'b0);
        send(8'hAA);
        chk("wb1 strobe", bus.reg_wr_strobe, 1'b1);
        chk("wb1 addr",   bus.reg_addr, 7'h05);
        chk("wb1 data",   bus.reg_wr_data, 8'hAA);
        send(8'h55);
        chk("wb2 strobe", bus.reg_wr_strobe, 1'b1);
        chk("wb2 addr",   bus.reg_addr, 7'h06);
        chk("wb2 data",   bus.reg_wr_data, 8'h55);
        cyc(1);
        chk("wb strobe pulse", bus.reg_wr_strobe, 1'b0);
        chk("wb addr hold",    bus.reg_addr, 7'h06);
        chk("wb no tx", tx_cnt - t0, 0);
        cs_rise();

        // preload 0x10/0x11 through the write path
        cs_fall();
        send(8'h10);
        send(8'h3C);
        send(8'hC3);
        cs_rise();

        // read burst with one dummy byte
        t0 = tx_cnt;
        cs_fall();
        send(8'h90);
        chk("rd N+1 strobe", bus.reg_rd_strobe, 1'b1);
        chk("rd N+1 addr",   bus.reg_addr, 7'h10);
        cyc(1);
        chk("rd N+2 no strobe", bus.reg_rd_strobe, 1'b0);
        chk("rd N+2 no tx",     bus.tx_strobe, 1'b0);
        cyc(1);
        chk("rd N+3 tx",      bus.tx_strobe, 1'b1);
        chk("rd N+3 tx_data", bus.tx_data, 8'h3C);
        cyc(1);
        chk("rd tx pulse", bus.tx_strobe, 1'b0);
        chk("rd tx hold",  bus.tx_data, 8'h3C);
        send(8'h00);
        chk("rd dummy strobe", bus.reg_rd_strobe, 1'b1);
        chk("rd dummy addr",   bus.reg_addr, 7'h11);
        cyc(2);
        chk("rd dummy tx",      bus.tx_strobe, 1'b1);
        chk("rd dummy tx_data", bus.tx_data, 8'hC3);
        cs_rise();
        chk("rd tx count", tx_cnt - t0, 2);

        // address wrap; second bridge keeps a fixed address
        cs_fall();
        send(8'h7F);
        send(8'h11);
        chk("wrap1 addr", bus.reg_addr, 7'h7F);
        chk("wrap1 data", bus.reg_wr_data, 8'h11);
        chk("fix1 strobe", bus2.reg_wr_strobe, 1'b1);
        chk("fix1 addr",  bus2.reg_addr, 7'h7F);
        send(8'h22);
        chk("wrap2 addr", bus.reg_addr, 7'h00);
        chk("wrap2 data", bus.reg_wr_data, 8'h22);
        chk("fix2 addr",  bus2.reg_addr, 7'h7F);
        chk("fix2 data",  bus2.reg_wr_data, 8'h22);
        send(8'h33);
        chk("wrap3 addr", bus.reg_addr, 7'h01);
        chk("fix3 addr",  bus2.reg_addr, 7'h7F);
        cs_rise();

        // overrun during a read
        t0 = tx_cnt;
        e0 = err_cnt;
        cs_fall();
        send(8'h80);
        chk("ovr rd strobe", bus.reg_rd_strobe, 1'b1);
        chk("ovr rd addr",   bus.reg_addr, 7'h00);
        send(8'hEE);
        chk("ovr error", frame_error, 1'b1);
        cyc(1);
        chk("ovr error pulse", frame_error, 1'b0);
        chk("ovr tx",      bus.tx_strobe, 1'b1);
        chk("ovr tx_data", bus.tx_data, 8'h22);
        cyc(3);
        chk("ovr tx count",  tx_cnt - t0, 1);
        chk("ovr err count", err_cnt - e0, 1);
        cs_rise();

        // cs rises one cycle after the read strobe
        t0 = tx_cnt;
        cs_fall();
        rx_data   = 8'h90;
        rx_strobe = 1'b1;
        spi_cs_n  = 1'b1;
        cyc(1);
        rx_strobe = 1'b0;
        chk("abort rd strobe kept", bus.reg_rd_strobe, 1'b1);
        cyc(5);
        chk("abort no tx", tx_cnt - t0, 0);
        cs_fall();
        send(8'h91);
        chk("after abort rd addr", bus.reg_addr, 7'h11);
        cyc(2);
        chk("after abort tx",      bus.tx_strobe, 1'b1);
        chk("after abort tx_data", bus.tx_data, 8'hC3);
        cs_rise();

        // byte arriving together with the synchronised cs rise
        w0 = wr_cnt;
        e0 = err_cnt;
        cs_fall();
        send(8'h20);
        spi_cs_n = 1'b1;
        cyc(2);
        send(8'h99);
        chk("cs wins no write", bus.reg_wr_strobe, 1'b0);
        chk("cs wins no error", frame_error, 1'b0);
        cyc(3);
        chk("cs wins wr count",  wr_cnt - w0, 0);
        chk("cs wins err count", err_cnt - e0, 0);

        // inactivity timeout
        e0  = err_cnt;
        e20 = err2_cnt;
        cs_fall();
        send(8'h01);
        pulses    = 0;
        first_err = 0;
        for (int i = 2; i <= 25; i++) begin
            cyc(1);
            if (frame_error) begin
                pulses++;
                if (first_err == 0) first_err = i;
            end
        end
        chk("to pulse count", pulses, 1);
        chk("to pulse near 20 cycles", (first_err >= 20 && first_err <= 22), 1'b1);
        chk("to disabled no error", err2_cnt - e20, 0);
        send(8'h55);
        chk("to locked no write",   bus.reg_wr_strobe, 1'b0);
        chk("to disabled writes",   bus2.reg_wr_strobe, 1'b1);
        chk("to disabled addr",     bus2.reg_addr, 7'h01);
        send(8'h66);
        chk("to locked no write 2", bus.reg_wr_strobe, 1'b0);
        cs_rise();
        cs_fall();
        send(8'h02);
        send(8'h77);
        chk("to recover strobe", bus.reg_wr_strobe, 1'b1);
        chk("to recover addr",   bus.reg_addr, 7'h02);
        chk("to recover data",   bus.reg_wr_data, 8'h77);

        // asynchronous reset while a write strobe is out
        send(8'h33);
        chk("pre-reset strobe", bus.reg_wr_strobe, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst wr_strobe", bus.reg_wr_strobe, 1'b0);
        chk("arst reg_addr",  bus.reg_addr, 7'h00);
        chk("arst wr_data",   bus.reg_wr_data, 8'h00);
        chk("arst tx_data",   bus.tx_data, 8'h00);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
